fc_layer_sched: RTL and testbench
=================================

FC_LAYER_SCHED -- requirements
Module: fc_layer_sched

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning activation width.
REQ-002 SHALL have parameter IN, default 128, meaning inputs per frame.
REQ-003 SHALL have parameter NEURONS, default 10, meaning number of neuron datapaths scheduled.
REQ-004 SHALL have parameter ZW, default 22, meaning neuron result width (post-ReLU).
REQ-005 SHALL have parameter SETTLE, default 2, meaning wait cycles for the combinational multiply/adder tree; legal range is 0..15.
REQ-006 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-007 SHALL have port rst, input, 1; reset is synchronous and active-high.
REQ-008 SHALL have port in_data, input, WIDTH, which carries the activation stream.
REQ-009 SHALL have ports in_valid (input, 1) and in_ready (output, 1), which form the input handshake.
REQ-010 SHALL have port x_out, output, IN x WIDTH array, which drives the x inputs of every neuron datapath.
REQ-011 SHALL have port z_in, input, NEURONS x ZW array, which carries the combinational neuron results.
REQ-012 SHALL have port out_data, output, ZW, which carries the registered result.
REQ-013 SHALL have port out_idx, output, $clog2(NEURONS), which carries the neuron index of out_data.
REQ-014 SHALL have ports out_valid (output, 1), out_ready (input, 1) and out_last (output, 1) for the result handshake.
REQ-015 SHALL have port busy, output, 1, high in any state other than LOAD.

Function
REQ-016 SHALL implement FSM states LOAD, SETTLE and EMIT.
REQ-017 SHALL, in LOAD, assert in_ready=1; each in_valid&&in_ready writes in_data to buffer slot cnt and increments cnt.
REQ-018 SHALL, on acceptance with cnt==IN-1, go to SETTLE with cnt=0 and the settle counter=0.
REQ-019 SHALL ignore in_valid whenever in_ready=0, with no buffer write.
REQ-020 SHALL hold in_ready=0 in SETTLE and EMIT.
REQ-021 SHALL keep x_out equal to the buffer, unchanged outside LOAD writes.
REQ-022 SHALL stay in SETTLE for exactly SETTLE cycles, then load out_data<=z_in[0] and out_idx<=0, and enter EMIT.
REQ-023 SHALL, when SETTLE=0, go LOAD -> EMIT directly, with out_data<=z_in[0] captured on the edge after the last acceptance.
REQ-024 SHALL make first out_valid latency exactly 1+SETTLE cycles after the edge accepting input IN-1.
REQ-025 SHALL assert out_valid=1 in EMIT only.
REQ-026 SHALL hold out_data, out_idx and out_last stable while out_valid&&!out_ready.
REQ-027 SHALL, on handshake with out_idx<NEURONS-1, set out_idx+1 and out_data<=z_in[out_idx+1] with no bubble cycle.
REQ-028 SHALL assert out_last=1 exactly when out_valid && out_idx==NEURONS-1.
REQ-029 SHALL, on handshake with out_last=1, return to LOAD so that in_ready=1 on the next cycle.
REQ-030 SHALL have no simultaneous load/emit: frames are strictly serialized.

Reset
REQ-031 SHALL, on rst=1 at a clock edge, set state=LOAD, cnt=0, settle counter=0, all buffer slots=0, out_data=0, out_idx=0, out_valid=0, out_last=0 and busy=0; in_ready=1 once rst=0.
REQ-032 SHALL, on reset mid-frame in any state, discard the partial frame and pending results with no output handshake.
REQ-033 SHALL give rst priority over any simultaneous handshake.

Configuration
REQ-034 SHALL use macro FC_SCHED_ARGMAX_EN; when defined, add outputs am_idx ($clog2(NEURONS)) and am_valid (1).
REQ-035 SHALL, with FC_SCHED_ARGMAX_EN, track the running max of out_data as unsigned over the frame's handshakes using strict greater-than, so ties keep the lowest index.
REQ-036 SHALL, with FC_SCHED_ARGMAX_EN, pulse am_valid for 1 cycle on the cycle after the out_last handshake with am_idx=the winner; am_idx holds until the next pulse; reset sets am_idx=0 and am_valid=0.
REQ-037 SHALL, without FC_SCHED_ARGMAX_EN, omit these ports and the comparator logic, with all other behaviour identical.

Verification
REQ-038 Basic frame: IN=128, NEURONS=10, SETTLE=2; stream 0..127 with in_valid always 1; z_in[k]=100+k; out_ready=1 -> x_out[i]=i; out_valid rises 3 cycles after the last acceptance; outputs 100..109 with idx 0..9; out_last only on idx 9; in_ready=1 one cycle later.
REQ-039 Input gaps: in_valid toggles 1/0 -> exactly 128 writes in order; no write while in_valid=0.
REQ-040 Backpressure: out_ready=0 for 5 cycles at idx 3 -> out_data=103 and idx=3 held; resume with no loss or duplication.
REQ-041 Reset mid-EMIT: rst at idx 4 -> out_valid=0 next cycle; buffer zeroed; next full frame behaves as in REQ-038.
REQ-042 SETTLE=0: first out_valid one cycle after the last acceptance, out_data=z_in[0].
REQ-043 With FC_SCHED_ARGMAX_EN: z_in = {5,9,2,9,0,...} -> am_idx=1; am_valid pulses once, 1 cycle after the out_last handshake.

Source files
------------

// File: rtl/fc_layer_sched.sv
// fc_layer_sched: buffers IN activations, waits SETTLE cycles for the neuron tree, then emits NEURONS results.
// Optional argmax outputs (am_idx/am_valid) are enabled by defining FC_SCHED_ARGMAX_EN.
module fc_layer_sched #(
   parameter  int WIDTH   = 8,
   parameter  int IN      = 128,
   parameter  int NEURONS = 10,
   parameter  int ZW      = 22,
   parameter  int SETTLE  = 2,
   localparam int CW      = (IN > 1) ? $clog2(IN) : 1,
   localparam int IW      = (NEURONS > 1) ? $clog2(NEURONS) : 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [WIDTH-1:0] x_out [IN],
   input  logic [ZW-1:0]    z_in [NEURONS],
   output logic [ZW-1:0]    out_data,
   output logic [IW-1:0]    out_idx,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             out_last,
`ifdef FC_SCHED_ARGMAX_EN
   output logic [IW-1:0]    am_idx,
   output logic             am_valid,
`endif
   output logic             busy
);
   typedef enum logic [1:0] {S_LOAD, S_SETTLE, S_EMIT} state_t;
   state_t           state_q;
   logic [CW-1:0]    cnt_q;
   logic [3:0]       set_q;
   logic [WIDTH-1:0] buf_q [IN];
   logic [ZW-1:0]    out_data_q;
   logic [IW-1:0]    out_idx_q;
   logic             out_valid_q;
   logic             out_last_q;
   logic [IW-1:0]    nxt_idx;
   assign nxt_idx   = out_idx_q + IW'(1);
   assign in_ready  = (state_q == S_LOAD);
   assign busy      = (state_q != S_LOAD);
   assign x_out     = buf_q;
   assign out_data  = out_data_q;
   assign out_idx   = out_idx_q;
   assign out_valid = out_valid_q;
   assign out_last  = out_last_q;
   // The settle state always lasts SETTLE+1 cycles so z_in sees the final buffer write before capture.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_LOAD;
         cnt_q       <= '0;
         set_q       <= '0;
         out_data_q  <= '0;
         out_idx_q   <= '0;
         out_valid_q <= 1'b0;
         out_last_q  <= 1'b0;
         for (int i = 0; i < IN; i++) buf_q[i] <= '0;
      end else begin
         case (state_q)
            S_LOAD: if (in_valid) begin
               buf_q[cnt_q] <= in_data;
               if (cnt_q == CW'(IN - 1)) begin
                  cnt_q   <= '0;
                  set_q   <= '0;
                  state_q <= S_SETTLE;
               end else cnt_q <= cnt_q + CW'(1);
            end
            S_SETTLE: if (set_q == 4'(SETTLE)) begin
               out_data_q  <= z_in[0];
               out_idx_q   <= '0;
               out_valid_q <= 1'b1;
               out_last_q  <= (NEURONS == 1);
               state_q     <= S_EMIT;
            end else set_q <= set_q + 4'd1;
            S_EMIT: if (out_ready) begin
               if (out_last_q) begin
                  out_valid_q <= 1'b0;
                  out_last_q  <= 1'b0;
                  state_q     <= S_LOAD;
               end else begin
                  out_idx_q  <= nxt_idx;
                  out_data_q <= z_in[nxt_idx];
                  out_last_q <= (nxt_idx == IW'(NEURONS - 1));
               end
            end
            default: state_q <= S_LOAD;
         endcase
      end
   end
`ifdef FC_SCHED_ARGMAX_EN
   logic [ZW-1:0] max_q;
   logic [IW-1:0] max_idx_q;
   logic [IW-1:0] am_idx_q;
   logic          am_valid_q;
   logic          hs;
   logic          take;
   assign hs       = out_valid_q && out_ready;
   assign take     = (out_idx_q == '0) || (out_data_q > max_q);
   assign am_idx   = am_idx_q;
   assign am_valid = am_valid_q;
   always_ff @(posedge clk) begin
      if (rst) begin
         max_q      <= '0;
         max_idx_q  <= '0;
         am_idx_q   <= '0;
         am_valid_q <= 1'b0;
      end else begin
         am_valid_q <= 1'b0;
         if (hs) begin
            if (take) begin
               max_q     <= out_data_q;
               max_idx_q <= out_idx_q;
            end
            if (out_last_q) begin
               am_valid_q <= 1'b1;
               am_idx_q   <= take ? out_idx_q : max_idx_q;
            end
         end
      end
   end
`endif
endmodule

// File: tb/tb_fc_layer_sched.sv
// tb_fc_layer_sched: directed tests of frame load, settle latency, emit handshake, reset and argmax.
module tb_fc_layer_sched;
   localparam int IN = 128, N = 10, ZW = 22;
   logic          clk = 1'b0;
   logic          rst;
   logic [7:0]    in_data;
   logic          in_valid;
   logic          out_ready;
   logic [ZW-1:0] z_in [N];
   logic          in_ready, busy, out_valid, out_last;
   logic [7:0]    x_out [IN];
   logic [ZW-1:0] out_data;
   logic [3:0]    out_idx;
   logic          in_ready_0, busy_0, out_valid_0, out_last_0;
   logic [7:0]    x_out_0 [IN];
   logic [ZW-1:0] out_data_0;
   logic [3:0]    out_idx_0;
`ifdef FC_SCHED_ARGMAX_EN
   logic [3:0]    am_idx, am_idx_0;
   logic          am_valid, am_valid_0;
`endif
   int checks = 0;
   int errors = 0;
   always #5 clk = ~clk;
   fc_layer_sched #(.WIDTH(8), .IN(IN), .NEURONS(N), .ZW(ZW), .SETTLE(2)) dut (
      .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
      .x_out(x_out), .z_in(z_in), .out_data(out_data), .out_idx(out_idx),
      .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
`ifdef FC_SCHED_ARGMAX_EN
      .am_idx(am_idx), .am_valid(am_valid),
`endif
      .busy(busy));
   fc_layer_sched #(.WIDTH(8), .IN(IN), .NEURONS(N), .ZW(ZW), .SETTLE(0)) dut0 (
      .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready_0),
      .x_out(x_out_0), .z_in(z_in), .out_data(out_data_0), .out_idx(out_idx_0),
      .out_valid(out_valid_0), .out_ready(out_ready), .out_last(out_last_0),
`ifdef FC_SCHED_ARGMAX_EN
      .am_idx(am_idx_0), .am_valid(am_valid_0),
`endif
      .busy(busy_0));
   task automatic set_z_linear();
      for (int k = 0; k < N; k++) z_in[k] = ZW'(100 + k);
   endtask
   task automatic send_frame(input bit gaps);
      for (int i = 0; i < IN; i++) begin
         if (gaps) begin
            in_valid = 1'b0;
            in_data  = 8'hEE;
            @(negedge clk);
         end
         in_valid = 1'b1;
         in_data  = i[7:0];
         @(negedge clk);
      end
      in_valid = 1'b0;
      in_data  = 8'h00;
   endtask
   task automatic wait_valid(output int lat);
      lat = 0;
      for (int n = 1; n <= 20; n++) begin
         @(negedge clk);
         if (out_valid) begin
            lat = n;
            break;
         end
      end
   endtask
   task automatic test_reset();
      rst = 1'b1; in_valid = 1'b1; in_data = 8'h55; out_ready = 1'b1;
      repeat (2) @(negedge clk);
      checks++;
      if ({out_valid, out_last, busy, in_ready} !== 4'b0001 || out_data !== '0 || out_idx !== '0) begin
         errors++;
         $display("FAIL reset_outputs: valid=%b last=%b busy=%b in_ready=%b data=%0d idx=%0d, want 0 0 0 1 0 0",
                  out_valid, out_last, busy, in_ready, out_data, out_idx);
      end
      rst = 1'b0; in_valid = 1'b0;
      @(negedge clk);
      checks++;
      if (x_out[0] !== 8'h00 || x_out[IN-1] !== 8'h00 || in_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_buffer: x0=%0h x127=%0h in_ready=%b, want 0 0 1", x_out[0], x_out[IN-1], in_ready);
      end
   endtask
   task automatic test_frame(input bit gaps, input int stall_at, input int stall_n, input int rst_at);
      int lat;
      int bad;
      set_z_linear();
      out_ready = 1'b1;
      send_frame(gaps);
      checks++;
      if (in_ready !== 1'b0 || busy !== 1'b1) begin
         errors++;
         $display("FAIL busy_after_load: in_ready=%b busy=%b, want 0 1", in_ready, busy);
      end
      wait_valid(lat);
      checks++;
      if (lat != 3) begin
         errors++;
         $display("FAIL first_latency: got %0d cycles, want 3", lat);
      end
      bad = 0;
      for (int i = 0; i < IN; i++) if (x_out[i] !== i[7:0]) bad++;
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL x_out_contents: %0d slots wrong (x5=%0h x127=%0h), want x[i]=i", bad, x_out[5], x_out[IN-1]);
      end
      for (int k = 0; k < N; k++) begin
         if (k == rst_at) begin
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
            checks++;
            if (out_valid !== 1'b0 || out_idx !== '0 || busy !== 1'b0 || x_out[5] !== 8'h00) begin
               errors++;
               $display("FAIL reset_mid_emit: valid=%b idx=%0d busy=%b x5=%0h, want 0 0 0 0", out_valid, out_idx, busy, x_out[5]);
            end
            return;
         end
         if (k == stall_at) begin
            out_ready = 1'b0;
            repeat (stall_n) begin
               @(negedge clk);
               checks++;
               if (out_valid !== 1'b1 || out_data !== ZW'(100 + k) || out_idx !== 4'(k)) begin
                  errors++;
                  $display("FAIL stall_hold: valid=%b data=%0d idx=%0d, want 1 %0d %0d", out_valid, out_data, out_idx, 100 + k, k);
               end
            end
            out_ready = 1'b1;
         end
         checks++;
         if (out_valid !== 1'b1 || out_data !== ZW'(100 + k) || out_idx !== 4'(k) || out_last !== (k == N - 1)) begin
            errors++;
            $display("FAIL emit_%0d: valid=%b data=%0d idx=%0d last=%b, want 1 %0d %0d %b",
                     k, out_valid, out_data, out_idx, out_last, 100 + k, k, k == N - 1);
         end
         @(negedge clk);
      end
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         errors++;
         $display("FAIL frame_return: valid=%b in_ready=%b, want 0 1", out_valid, in_ready);
      end
   endtask
   task automatic test_settle0();
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      set_z_linear();
      out_ready = 1'b1;
      send_frame(1'b0);
      checks++;
      if (out_valid_0 !== 1'b0) begin
         errors++;
         $display("FAIL settle0_early: valid=%b, want 0", out_valid_0);
      end
      @(negedge clk);
      checks++;
      if (out_valid_0 !== 1'b1 || out_data_0 !== ZW'(100) || out_idx_0 !== 4'd0) begin
         errors++;
         $display("FAIL settle0_first: valid=%b data=%0d idx=%0d, want 1 100 0", out_valid_0, out_data_0, out_idx_0);
      end
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
   endtask
`ifdef FC_SCHED_ARGMAX_EN
   task automatic test_argmax();
      int lat;
      for (int k = 0; k < N; k++) z_in[k] = '0;
      z_in[0] = 5; z_in[1] = 9; z_in[2] = 2; z_in[3] = 9;
      out_ready = 1'b1;
      send_frame(1'b0);
      wait_valid(lat);
      for (int k = 0; k < N; k++) begin
         checks++;
         if (am_valid !== 1'b0) begin
            errors++;
            $display("FAIL argmax_early_%0d: am_valid=%b, want 0", k, am_valid);
         end
         @(negedge clk);
      end
      checks++;
      if (am_valid !== 1'b1 || am_idx !== 4'd1) begin
         errors++;
         $display("FAIL argmax_pulse: am_valid=%b am_idx=%0d, want 1 1", am_valid, am_idx);
      end
      @(negedge clk);
      checks++;
      if (am_valid !== 1'b0 || am_idx !== 4'd1) begin
         errors++;
         $display("FAIL argmax_hold: am_valid=%b am_idx=%0d, want 0 1", am_valid, am_idx);
      end
   endtask
`endif
   initial begin
      rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
      set_z_linear();
      test_reset();
      test_frame(1'b0, -1, 0, -1);
      test_frame(1'b1, -1, 0, -1);
      test_frame(1'b0, 3, 5, -1);
      test_frame(1'b0, -1, 0, 4);
      test_frame(1'b0, -1, 0, -1);
      test_settle0();
`ifdef FC_SCHED_ARGMAX_EN
      test_argmax();
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
